crc_router: RTL and testbench

CRC_ROUTER -- requirements
Module: crc_router

---
 rtl/crc_router_pkg.sv | 28 ++
 rtl/crc_router_rr_arbiter.sv | 60 ++++++
 rtl/crc_router.sv | 152 +++++++++++++++
 tb/tb_crc_router.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_router_pkg.sv
// crc_router_pkg: shared constants and the CRC-4 helper for the CRC router.
// Rev 1.0
`default_nettype none

package crc_router_pkg;

  localparam int         ADDR_W    = 4;
  localparam int         ERR_W     = 16;
  localparam logic [3:0] CRC_POLY  = 4'h3;
  localparam int         CRC_MAX_W = 128;

  // Serial LFSR form of M(x)*x^4 mod (x^4+x+1), MSB first, init 0. Leading
  // zeros leave the remainder unchanged, so narrower payloads are zero-extended.
  function automatic logic [3:0] crc4(input logic [CRC_MAX_W-1:0] data);
    logic [3:0] c;
    logic       fb;
    c = '0;
    for (int i = CRC_MAX_W - 1; i >= 0; i--) begin
      fb = c[3] ^ data[i];
      c  = {c[2:0], 1'b0};
      if (fb) c = c ^ CRC_POLY;
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/crc_router_rr_arbiter.sv
// rr_arbiter: round-robin grant of one requester per cycle, search from last grant + 1.
// Rev 1.0
`default_nettype none

module rr_arbiter
  import crc_router_pkg::*;
#(
  parameter int N = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [N-1:0]      req,
  input  logic              advance,
  output logic [N-1:0]      grant,
  output logic [ADDR_W-1:0] grant_idx
);

  localparam int CW = ADDR_W + 1;

  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [CW-1:0]     cand;
  logic              found;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int k = 0; k < N; k++) begin
      cand = {1'b0, ptr_q} + CW'(k + 1);
      if (cand >= CW'(N)) cand = cand - CW'(N);
      for (int p = 0; p < N; p++) begin
        if (!found && req[p] && (cand == CW'(p))) begin
          found     = 1'b1;
          grant_idx = ADDR_W'(p);
        end
      end
    end
  end

  always_comb begin
    grant = '0;
    for (int p = 0; p < N; p++) begin
      grant[p] = found && (grant_idx == ADDR_W'(p));
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance && found) ptr_d = grant_idx;
  end

  // Pointer resets to the last channel so channel 0 has first priority.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ptr_q <= ADDR_W'(N - 1);
    else          ptr_q <= ptr_d;
  end

endmodule

`default_nettype wire

// File: rtl/crc_router.sv
// crc_router: per-channel holding registers, round-robin drain, CRC-4/dest check, routed delivery.
// Rev 1.0
`default_nettype none

module crc_router
  import crc_router_pkg::*;
#(
  parameter int NPORTS = 16,
  parameter int DATA_W = 64,
  parameter int CRC_EN = 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic [NPORTS-1:0]          in_valid,
  output logic [NPORTS-1:0]          in_ready,
  input  logic [NPORTS*DATA_W-1:0]   in_data,
  input  logic [NPORTS*4-1:0]        in_crc,
  input  logic [NPORTS*ADDR_W-1:0]   in_dest,
  output logic [NPORTS-1:0]          out_valid,
  output logic [NPORTS*DATA_W-1:0]   out_data,
  output logic [NPORTS*ADDR_W-1:0]   out_src,
  output logic [ERR_W-1:0]           err_cnt,
  output logic                       drop
);

  localparam int CW = ADDR_W + 1;

  logic [NPORTS-1:0] full_q, full_d;
  logic [DATA_W-1:0] hold_data_q [NPORTS];
  logic [DATA_W-1:0] hold_data_d [NPORTS];
  logic [3:0]        hold_crc_q  [NPORTS];
  logic [3:0]        hold_crc_d  [NPORTS];
  logic [ADDR_W-1:0] hold_dest_q [NPORTS];
  logic [ADDR_W-1:0] hold_dest_d [NPORTS];

  logic [NPORTS-1:0] out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q  [NPORTS];
  logic [DATA_W-1:0] out_data_d  [NPORTS];
  logic [ADDR_W-1:0] out_src_q   [NPORTS];
  logic [ADDR_W-1:0] out_src_d   [NPORTS];
  logic [ERR_W-1:0]  err_q, err_d;
  logic              drop_q, drop_d;

  logic [NPORTS-1:0] accept;
  logic [NPORTS-1:0] grant;
  logic [ADDR_W-1:0] grant_idx;
  logic [DATA_W-1:0] sel_data;
  logic [3:0]        sel_crc;
  logic [ADDR_W-1:0] sel_dest;
  logic              crc_ok, dest_ok, good, bad;

  assign accept = in_valid & ~full_q;

  rr_arbiter #(.N(NPORTS)) u_arb (
    .clock     (clock),
    .reset_n   (reset_n),
    .req       (full_q),
    .advance   (|full_q),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_data = '0;
    sel_crc  = '0;
    sel_dest = '0;
    for (int p = 0; p < NPORTS; p++) begin
      if (grant[p]) begin
        sel_data = hold_data_q[p];
        sel_crc  = hold_crc_q[p];
        sel_dest = hold_dest_q[p];
      end
    end
  end

  assign crc_ok  = (CRC_EN == 0) || (crc4(CRC_MAX_W'(sel_data)) == sel_crc);
  assign dest_ok = ({1'b0, sel_dest} < CW'(NPORTS));
  assign good    = (|grant) && crc_ok && dest_ok;
  assign bad     = (|grant) && !(crc_ok && dest_ok);

  // Accept only into empty slots and grant only full ones, so the two never collide.
  always_comb begin
    full_d = (full_q | accept) & ~grant;
    for (int p = 0; p < NPORTS; p++) begin
      hold_data_d[p] = hold_data_q[p];
      hold_crc_d[p]  = hold_crc_q[p];
      hold_dest_d[p] = hold_dest_q[p];
      if (accept[p]) begin
        hold_data_d[p] = in_data[p*DATA_W +: DATA_W];
        hold_crc_d[p]  = in_crc[p*4 +: 4];
        hold_dest_d[p] = in_dest[p*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    out_valid_d = '0;
    drop_d      = bad;
    err_d       = err_q;
    if (bad && (err_q != '1)) err_d = err_q + 1'b1;
    for (int p = 0; p < NPORTS; p++) begin
      out_data_d[p] = out_data_q[p];
      out_src_d[p]  = out_src_q[p];
      if (good && (sel_dest == ADDR_W'(p))) begin
        out_valid_d[p] = 1'b1;
        out_data_d[p]  = sel_data;
        out_src_d[p]   = grant_idx;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full_q      <= '0;
      out_valid_q <= '0;
      err_q       <= '0;
      drop_q      <= 1'b0;
      for (int p = 0; p < NPORTS; p++) begin
        hold_data_q[p] <= '0;
        hold_crc_q[p]  <= '0;
        hold_dest_q[p] <= '0;
        out_data_q[p]  <= '0;
        out_src_q[p]   <= '0;
      end
    end else begin
      full_q      <= full_d;
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
      for (int p = 0; p < NPORTS; p++) begin
        hold_data_q[p] <= hold_data_d[p];
        hold_crc_q[p]  <= hold_crc_d[p];
        hold_dest_q[p] <= hold_dest_d[p];
        out_data_q[p]  <= out_data_d[p];
        out_src_q[p]   <= out_src_d[p];
      end
    end
  end

  assign in_ready  = ~full_q;
  assign out_valid = out_valid_q;
  assign err_cnt   = err_q;
  assign drop      = drop_q;

  for (genvar p = 0; p < NPORTS; p++) begin : g_out
    assign out_data[p*DATA_W +: DATA_W] = out_data_q[p];
    assign out_src[p*ADDR_W +: ADDR_W]  = out_src_q[p];
  end

endmodule

`default_nettype wire

// File: tb/tb_crc_router.sv
// tb_crc_router: vector table, directed corner sequences and randomized scoreboard run.
// Rev 1.0
`default_nettype none

module tb_crc_router;

  logic clock;
  logic reset_n;

  logic [15:0]     in_valid, in_ready, out_valid;
  logic [16*64-1:0] in_data, out_data;
  logic [16*4-1:0] in_crc, in_dest, out_src;
  logic [15:0]     err_cnt;
  logic            drop;

  logic [15:0]     nc_in_valid, nc_in_ready, nc_out_valid;
  logic [16*64-1:0] nc_in_data, nc_out_data;
  logic [16*4-1:0] nc_in_crc, nc_in_dest, nc_out_src;
  logic [15:0]     nc_err_cnt;
  logic            nc_drop;

  logic [11:0]     s_in_valid, s_in_ready, s_out_valid;
  logic [12*64-1:0] s_in_data, s_out_data;
  logic [12*4-1:0] s_in_crc, s_in_dest, s_out_src;
  logic [15:0]     s_err_cnt;
  logic            s_drop;

  crc_router #(.NPORTS(16), .DATA_W(64), .CRC_EN(1)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_crc(in_crc), .in_dest(in_dest), .out_valid(out_valid),
    .out_data(out_data), .out_src(out_src), .err_cnt(err_cnt), .drop(drop)
  );

  crc_router #(.NPORTS(16), .DATA_W(64), .CRC_EN(0)) dut_nc (
    .clock(clock), .reset_n(reset_n), .in_valid(nc_in_valid), .in_ready(nc_in_ready),
    .in_data(nc_in_data), .in_crc(nc_in_crc), .in_dest(nc_in_dest), .out_valid(nc_out_valid),
    .out_data(nc_out_data), .out_src(nc_out_src), .err_cnt(nc_err_cnt), .drop(nc_drop)
  );

  crc_router #(.NPORTS(12), .DATA_W(64), .CRC_EN(1)) dut12 (
    .clock(clock), .reset_n(reset_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_crc(s_in_crc), .in_dest(s_in_dest), .out_valid(s_out_valid),
    .out_data(s_out_data), .out_src(s_out_src), .err_cnt(s_err_cnt), .drop(s_drop)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference CRC by polynomial long division of M(x)*x^4 by x^4+x+1.
  function automatic logic [3:0] ref_crc(input logic [63:0] d);
    logic [67:0] r;
    r = {d, 4'b0000};
    for (int b = 67; b >= 4; b--) begin
      if (r[b]) r[b -: 5] = r[b -: 5] ^ 5'b10011;
    end
    return r[3:0];
  endfunction

  typedef struct {
    int          src;
    logic [63:0] data;
    logic [3:0]  crc;
    int          dest;
    bit          drop;
  } vec_t;

  typedef struct {
    int          src;
    int          dest;
    logic [63:0] data;
  } exp_t;

  vec_t vec [7];
  exp_t exp_q [$];
  int   err_exp;

  task automatic clear_inputs();
    in_valid = '0; in_data = '0; in_crc = '0; in_dest = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic drive(input int ch, input logic [63:0] d, input logic [3:0] c, input int dst);
    in_valid[ch]          = 1'b1;
    in_data[ch*64 +: 64]  = d;
    in_crc[ch*4 +: 4]     = c;
    in_dest[ch*4 +: 4]    = 4'(dst);
  endtask

  task automatic apply_row(input vec_t v);
    drive(v.src, v.data, v.crc, v.dest);
    @(negedge clock);
    in_valid = '0;
    chk("row_ready_low", 128'(in_ready[v.src]), 128'(0));
    chk("row_no_early_valid", 128'(out_valid), 128'(0));
    @(negedge clock);
    if (v.drop) begin
      err_exp++;
      chk("row_drop_valid", 128'(out_valid), 128'(0));
      chk("row_drop_strobe", 128'(drop), 128'(1));
      chk("row_drop_errcnt", 128'(err_cnt), 128'(err_exp));
    end else begin
      chk("row_out_valid", 128'(out_valid), 128'(16'(1) << v.dest));
      chk("row_out_data", 128'(out_data[v.dest*64 +: 64]), 128'(v.data));
      chk("row_out_src", 128'(out_src[v.dest*4 +: 4]), 128'(v.src));
      chk("row_no_drop", 128'(drop), 128'(0));
    end
    @(negedge clock);
    chk("row_valid_oneshot", 128'(out_valid), 128'(0));
    chk("row_drop_oneshot", 128'(drop), 128'(0));
    if (!v.drop) chk("row_data_hold", 128'(out_data[v.dest*64 +: 64]), 128'(v.data));
  endtask

  task automatic monitor_cycle(inout int drops_seen);
    int   d;
    int   s;
    int   hit;
    if ($countones(out_valid) > 1) chk("rand_onehot", 128'($countones(out_valid)), 128'(1));
    if (out_valid != 0) begin
      d = 0;
      for (int p = 0; p < 16; p++) if (out_valid[p]) d = p;
      s   = int'(out_src[d*4 +: 4]);
      hit = -1;
      for (int k = 0; k < exp_q.size(); k++) begin
        if (hit < 0 && exp_q[k].src == s) hit = k;
      end
      if (hit < 0) begin
        chk("rand_unexpected_src", 128'(s), 128'(16));
      end else begin
        chk("rand_data", 128'(out_data[d*64 +: 64]), 128'(exp_q[hit].data));
        chk("rand_dest", 128'(d), 128'(exp_q[hit].dest));
        exp_q.delete(hit);
      end
    end
    if (drop) drops_seen++;
  endtask

  initial begin
    int          bad_sent;
    int          drops_seen;
    int          sent;
    int          recv;
    logic [63:0] d;
    logic [3:0]  c;
    bit          isbad;

    vec[0] = '{src: 3,  data: 64'h1,  crc: 4'h3, dest: 9,  drop: 1'b0};
    vec[1] = '{src: 0,  data: 64'h2,  crc: 4'h5, dest: 4,  drop: 1'b1};
    vec[2] = '{src: 0,  data: 64'h2,  crc: 4'h6, dest: 4,  drop: 1'b0};
    vec[3] = '{src: 7,  data: 64'h0,  crc: 4'h0, dest: 7,  drop: 1'b0};
    vec[4] = '{src: 15, data: 64'h3,  crc: 4'h5, dest: 0,  drop: 1'b0};
    vec[5] = '{src: 5,  data: 64'h10, crc: 4'h5, dest: 15, drop: 1'b0};
    vec[6] = '{src: 9,  data: 64'h10, crc: 4'h4, dest: 1,  drop: 1'b1};

    reset_n = 1'b0;
    clear_inputs();
    nc_in_valid = '0; nc_in_data = '0; nc_in_crc = '0; nc_in_dest = '0;
    s_in_valid = '0;  s_in_data = '0;  s_in_crc = '0;  s_in_dest = '0;
    repeat (2) @(negedge clock);

    chk("rst_in_ready", 128'(in_ready), 128'(16'hFFFF));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_out_src", 128'(out_src), 128'(0));
    chk("rst_err_cnt", 128'(err_cnt), 128'(0));
    chk("rst_drop", 128'(drop), 128'(0));
    chk("rst_ready12", 128'(s_in_ready), 128'(12'hFFF));

    reset_n = 1'b1;
    err_exp = 0;
    for (int r = 0; r < 7; r++) apply_row(vec[r]);

    // Bypass instance delivers the bad-CRC beat; 12-port instance drops dest 13.
    nc_in_valid[0] = 1'b1; nc_in_data[63:0] = 64'h2; nc_in_crc[3:0] = 4'h5; nc_in_dest[3:0] = 4'd4;
    s_in_valid[11] = 1'b1; s_in_data[11*64 +: 64] = 64'h0; s_in_crc[11*4 +: 4] = 4'h0;
    s_in_dest[11*4 +: 4] = 4'd13;
    @(negedge clock);
    nc_in_valid = '0; s_in_valid = '0;
    @(negedge clock);
    chk("nc_out_valid", 128'(nc_out_valid), 128'(16'h0010));
    chk("nc_out_data", 128'(nc_out_data[4*64 +: 64]), 128'(64'h2));
    chk("nc_no_drop", 128'(nc_drop), 128'(0));
    chk("s12_drop", 128'(s_drop), 128'(1));
    chk("s12_no_valid", 128'(s_out_valid), 128'(0));
    chk("s12_err_cnt", 128'(s_err_cnt), 128'(1));
    @(negedge clock);

    // Contention: three channels into dest 2 from a fresh pointer.
    do_reset();
    drive(0,  64'h100, ref_crc(64'h100), 2);
    drive(5,  64'h105, ref_crc(64'h105), 2);
    drive(15, 64'h10F, ref_crc(64'h10F), 2);
    @(negedge clock);
    clear_inputs();
    chk("cont_wait", 128'(out_valid), 128'(0));
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("cont_valid", 128'(out_valid), 128'(16'h0004));
      chk("cont_src", 128'(out_src[2*4 +: 4]), 128'(k == 0 ? 0 : (k == 1 ? 5 : 15)));
      chk("cont_data", 128'(out_data[2*64 +: 64]), 128'(k == 0 ? 64'h100 : (k == 1 ? 64'h105 : 64'h10F)));
    end
    drive(3,  64'h203, ref_crc(64'h203), 2);
    drive(15, 64'h20F, ref_crc(64'h20F), 2);
    @(negedge clock);
    clear_inputs();
    chk("cont2_gap", 128'(out_valid), 128'(0));
    @(negedge clock);
    chk("cont2_first_src", 128'(out_src[2*4 +: 4]), 128'(3));
    @(negedge clock);
    chk("cont2_second_src", 128'(out_src[2*4 +: 4]), 128'(15));
    chk("cont2_second_valid", 128'(out_valid), 128'(16'h0004));

    // Back-pressure: channel 1 streams 100 beats with in_valid held high.
    do_reset();
    sent = 0;
    recv = 0;
    for (int k = 0; k < 206; k++) begin
      if (k < 200) chk("bp_ready", 128'(in_ready[1]), 128'(k % 2 == 0));
      if (out_valid != 0) begin
        chk("bp_valid", 128'(out_valid), 128'(16'h0040));
        chk("bp_data", 128'(out_data[6*64 +: 64]), 128'(64'h1000 + 64'(recv)));
        recv++;
      end
      if (in_ready[1] && sent < 100) begin
        d = 64'h1000 + 64'(sent);
        drive(1, d, ref_crc(d), 6);
        sent++;
      end else if (in_ready[1]) begin
        in_valid[1] = 1'b0;
      end
      @(negedge clock);
    end
    chk("bp_count", 128'(recv), 128'(100));

    // Reset pulsed while four channels are held.
    clear_inputs();
    @(negedge clock);
    for (int ch = 1; ch <= 4; ch++) drive(ch, 64'h55 + 64'(ch), ref_crc(64'h55 + 64'(ch)), 0);
    @(negedge clock);
    clear_inputs();
    chk("mf_held", 128'(in_ready[4:1]), 128'(0));
    #2 reset_n = 1'b0;
    #1;
    chk("mf_ready_in_reset", 128'(in_ready), 128'(16'hFFFF));
    chk("mf_valid_in_reset", 128'(out_valid), 128'(0));
    @(negedge clock);
    reset_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk("mf_no_strobe", 128'({out_valid, drop}), 128'(0));
    end
    chk("mf_ready_after", 128'(in_ready), 128'(16'hFFFF));
    chk("mf_err_cnt", 128'(err_cnt), 128'(0));

    // Randomized traffic against the scoreboard.
    do_reset();
    bad_sent   = 0;
    drops_seen = 0;
    for (int cyc = 0; cyc < 3050; cyc++) begin
      monitor_cycle(drops_seen);
      for (int i = 0; i < 16; i++) begin
        if (cyc < 3000 && $urandom_range(0, 99) < 40) begin
          d     = {$urandom, $urandom};
          isbad = ($urandom_range(0, 3) == 0);
          c     = ref_crc(d) ^ (isbad ? 4'($urandom_range(1, 15)) : 4'h0);
          drive(i, d, c, int'($urandom_range(0, 15)));
          if (in_ready[i]) begin
            if (isbad) bad_sent++;
            else exp_q.push_back('{src: i, dest: int'(in_dest[i*4 +: 4]), data: d});
          end
        end else begin
          in_valid[i] = 1'b0;
        end
      end
      @(negedge clock);
    end
    chk("rand_all_delivered", 128'(exp_q.size()), 128'(0));
    chk("rand_drop_count", 128'(drops_seen), 128'(bad_sent));
    chk("rand_err_cnt", 128'(err_cnt), 128'(bad_sent));

    // Saturation on the 12-port instance: every channel streams to dest 13.
    s_in_valid = 12'hFFF;
    for (int i = 0; i < 12; i++) begin
      s_in_data[i*64 +: 64] = 64'h0;
      s_in_crc[i*4 +: 4]    = 4'h0;
      s_in_dest[i*4 +: 4]   = 4'd13;
    end
    repeat (70010) @(negedge clock);
    chk("sat_err_cnt", 128'(s_err_cnt), 128'(16'hFFFF));
    chk("sat_drop_still", 128'(s_drop), 128'(1));
    chk("sat_no_valid", 128'(s_out_valid), 128'(0));
    s_in_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
